// File: rtl/spis_avbbuf.sv
// SPI-slave side register/buffer stage feeding the AVMM bridge: command register,
// write-data FIFO (SPI -> bridge) and read-data FIFO (bridge -> SPI).
module spis_avbbuf #(
    parameter int WBUF_DEPTH = 16,
    parameter int RBUF_DEPTH = 16
) (
    input  logic        s_avmm_clk,
    input  logic        s_avmm_rst_n,
    input  logic        spi_wr,
    input  logic        spi_rd,
    input  logic [15:0] spi_addr,
    input  logic [31:0] spi_wdata,
    output logic [31:0] spi_rdata,
    output logic        spi_rdvld,
    output logic [7:0]  avmm_brstlen,
    output logic [1:0]  avmm_sel,
    output logic [16:0] avmm_offset,
    output logic        avmm_rdnwr,
    output logic        avmm_transvld,
    input  logic        avmmtransvld_up,
    output logic [31:0] reg2avb_wdata,
    input  logic        avb2reg_read_pulse,
    input  logic        avb2reg_write,
    input  logic [31:0] avb2reg_rdata_q,
    input  logic [15:0] avb2reg_addr,
    output logic        busy
);
    localparam int WAW = $clog2(WBUF_DEPTH);
    localparam int RAW = $clog2(RBUF_DEPTH);

    localparam logic [15:0] ADDR_CMD    = 16'h0000;
    localparam logic [15:0] ADDR_STATUS = 16'h0004;
    localparam logic [15:0] ADDR_WBUF   = 16'h0200;
    localparam logic [15:0] ADDR_RBUF   = 16'h1000;

    localparam int ST_DONE = 0, ST_CMD_ERR = 1, ST_WOVF = 2, ST_WUDF = 3,
                   ST_ROVF = 4, ST_RUDF = 5, ST_ADDR_ERR = 6;

    // Field order mirrors the CMD register layout, bits [28:0].
    typedef struct packed {
        logic [16:0] offset;
        logic        transvld;
        logic        rdnwr;
        logic [1:0]  sel;
        logic [7:0]  brstlen;
    } cmd_t;

    cmd_t        cmd_q, cmd_d, wcmd;
    logic [6:0]  status_q, status_d, st_set, st_clr;

    logic [31:0] w_mem [WBUF_DEPTH];
    logic [31:0] r_mem [RBUF_DEPTH];
    logic [WAW:0] w_wr_ptr, w_rd_ptr, w_cnt;
    logic [RAW:0] r_wr_ptr, r_rd_ptr, r_cnt;
    logic [8:0]  w_cnt9, r_cnt9, r_free9;
    logic        w_full, w_empty, r_full, r_empty;
    logic [31:0] w_head, r_head;

    logic        rd_en, wr_cmd, wr_status, w_push, w_push_ok, w_pop_ok;
    logic        r_push_addr_ok, r_push_ok, r_pop, r_pop_ok;
    logic        cmd_ok, cmd_accept;
    logic [31:0] rdata_d;
    logic        unused_bits;

    assign w_cnt   = w_wr_ptr - w_rd_ptr;
    assign r_cnt   = r_wr_ptr - r_rd_ptr;
    assign w_cnt9  = 9'(w_cnt);
    assign r_cnt9  = 9'(r_cnt);
    assign r_free9 = 9'(RBUF_DEPTH) - r_cnt9;
    assign w_full  = (w_cnt9 == 9'(WBUF_DEPTH));
    assign r_full  = (r_cnt9 == 9'(RBUF_DEPTH));
    assign w_empty = (w_cnt9 == 9'd0);
    assign r_empty = (r_cnt9 == 9'd0);
    assign w_head  = w_empty ? 32'd0 : w_mem[w_rd_ptr[WAW-1:0]];
    assign r_head  = r_empty ? 32'd0 : r_mem[r_rd_ptr[RAW-1:0]];

    assign busy          = cmd_q.transvld;
    assign avmm_transvld = cmd_q.transvld;
    assign avmm_brstlen  = cmd_q.brstlen;
    assign avmm_sel      = cmd_q.sel;
    assign avmm_offset   = cmd_q.offset;
    assign avmm_rdnwr    = cmd_q.rdnwr;
    assign reg2avb_wdata = w_head;
    assign unused_bits   = &{1'b0, spi_wdata[31:29]};

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        wcmd      = cmd_t'(spi_wdata[28:0]);
        rd_en     = spi_rd && !spi_wr;
        wr_cmd    = spi_wr && (spi_addr == ADDR_CMD);
        wr_status = spi_wr && (spi_addr == ADDR_STATUS);
        w_push    = spi_wr && (spi_addr == ADDR_WBUF);
        w_push_ok = w_push && !w_full;
        w_pop_ok  = avb2reg_read_pulse && !w_empty;
        r_push_addr_ok = (avb2reg_addr == ADDR_RBUF);
        r_push_ok = avb2reg_write && r_push_addr_ok && !r_full;
        r_pop     = rd_en && (spi_addr == ADDR_RBUF);
        r_pop_ok  = r_pop && !r_empty;

        cmd_ok = !busy && (wcmd.brstlen != 8'd0) && (wcmd.sel != 2'd3) &&
                 (wcmd.rdnwr ? (r_free9 >= {1'b0, wcmd.brstlen})
                             : (w_cnt9  >= {1'b0, wcmd.brstlen}));
        cmd_accept = wr_cmd && wcmd.transvld && cmd_ok;

        cmd_d = cmd_q;
        if (wr_cmd && !busy && (!wcmd.transvld || cmd_ok))
            cmd_d = wcmd;
        if (busy && avmmtransvld_up)
            cmd_d.transvld = 1'b0;

        st_clr = wr_status ? spi_wdata[6:0] : 7'd0;
        st_set = 7'd0;
        st_set[ST_DONE]     = busy && avmmtransvld_up;
        st_set[ST_CMD_ERR]  = wr_cmd && (busy || (wcmd.transvld && !cmd_ok));
        st_set[ST_WOVF]     = w_push && w_full;
        st_set[ST_WUDF]     = avb2reg_read_pulse && w_empty;
        st_set[ST_ROVF]     = avb2reg_write && r_full;
        st_set[ST_RUDF]     = r_pop && r_empty;
        st_set[ST_ADDR_ERR] = avb2reg_write && !r_push_addr_ok;
        status_d = (status_q & ~st_clr) | st_set;
        if (cmd_accept)
            status_d[ST_DONE] = 1'b0;

        rdata_d = 32'd0;
        case (spi_addr)
            ADDR_CMD:    rdata_d = {3'd0, cmd_q};
            ADDR_STATUS: rdata_d = {7'd0, busy, r_cnt9[7:0], w_cnt9[7:0], 1'b0, status_q};
            ADDR_WBUF:   rdata_d = w_head;
            ADDR_RBUF:   rdata_d = r_head;
            default:     rdata_d = 32'd0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge s_avmm_clk or negedge s_avmm_rst_n) begin
        if (!s_avmm_rst_n) begin
            cmd_q     <= '0;
            status_q  <= '0;
            w_wr_ptr  <= '0;
            w_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            spi_rdata <= '0;
            spi_rdvld <= 1'b0;
        end else begin
            cmd_q     <= cmd_d;
            status_q  <= status_d;
            spi_rdvld <= rd_en;
            if (rd_en)     spi_rdata <= rdata_d;
            if (w_push_ok) w_wr_ptr  <= w_wr_ptr + 1'b1;
            if (w_pop_ok)  w_rd_ptr  <= w_rd_ptr + 1'b1;
            if (r_push_ok) r_wr_ptr  <= r_wr_ptr + 1'b1;
            if (r_pop_ok)  r_rd_ptr  <= r_rd_ptr + 1'b1;
        end
    end

    // NOTE: FIFO storage is not reset; the reset pointers make stale contents unreachable.
    always_ff @(posedge s_avmm_clk) begin
        if (w_push_ok) w_mem[w_wr_ptr[WAW-1:0]] <= spi_wdata;
        if (r_push_ok) r_mem[r_wr_ptr[RAW-1:0]] <= avb2reg_rdata_q;
    end
endmodule

// File: tb/tb_spis_avbbuf.sv
// Directed bench for spis_avbbuf: a vector table for the main register/FIFO flows,
// then hand-written sequences for overflow, collision, read timing and async reset.
module tb_spis_avbbuf;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        spi_wr = 1'b0, spi_rd = 1'b0;
    logic [15:0] spi_addr = '0;
    logic [31:0] spi_wdata = '0;
    logic [31:0] spi_rdata;
    logic        spi_rdvld;
    logic [7:0]  avmm_brstlen;
    logic [1:0]  avmm_sel;
    logic [16:0] avmm_offset;
    logic        avmm_rdnwr, avmm_transvld, busy;
    logic        avmmtransvld_up = 1'b0;
    logic [31:0] reg2avb_wdata;
    logic        avb2reg_read_pulse = 1'b0, avb2reg_write = 1'b0;
    logic [31:0] avb2reg_rdata_q = '0;
    logic [15:0] avb2reg_addr = '0;

    int checks = 0;
    int failures = 0;

    spis_avbbuf #(.WBUF_DEPTH(16), .RBUF_DEPTH(16)) dut (
        .s_avmm_clk(clk), .s_avmm_rst_n(rst_n),
        .spi_wr(spi_wr), .spi_rd(spi_rd), .spi_addr(spi_addr),
        .spi_wdata(spi_wdata), .spi_rdata(spi_rdata), .spi_rdvld(spi_rdvld),
        .avmm_brstlen(avmm_brstlen), .avmm_sel(avmm_sel), .avmm_offset(avmm_offset),
        .avmm_rdnwr(avmm_rdnwr), .avmm_transvld(avmm_transvld),
        .avmmtransvld_up(avmmtransvld_up), .reg2avb_wdata(reg2avb_wdata),
        .avb2reg_read_pulse(avb2reg_read_pulse), .avb2reg_write(avb2reg_write),
        .avb2reg_rdata_q(avb2reg_rdata_q), .avb2reg_addr(avb2reg_addr), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef enum logic [2:0] {OP_WR, OP_RD, OP_OUTS, OP_BUSY, OP_HEAD, OP_POP, OP_PUSH, OP_UP} op_e;
    typedef struct {
        op_e         op;
        logic [15:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
        string       name;
    } vec_t;
    vec_t vecs[$];

    localparam logic [15:0] A_CMD = 16'h0000, A_ST = 16'h0004, A_WB = 16'h0200, A_RB = 16'h1000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {3'd0, avmm_offset, avmm_transvld, avmm_rdnwr, avmm_sel, avmm_brstlen};
    endfunction

    task automatic add(input op_e op, input logic [15:0] a, input logic [31:0] d,
                       input logic [31:0] e, input string n);
        vec_t v;
        v.op = op; v.addr = a; v.data = d; v.exp = e; v.name = n;
        vecs.push_back(v);
    endtask

    task automatic spi_write(input logic [15:0] a, input logic [31:0] d);
        @(negedge clk); spi_wr = 1'b1; spi_addr = a; spi_wdata = d;
        @(negedge clk); spi_wr = 1'b0;
    endtask

    task automatic spi_read(input logic [15:0] a, output logic [31:0] d, output logic v);
        @(negedge clk); spi_rd = 1'b1; spi_addr = a;
        @(negedge clk); spi_rd = 1'b0; d = spi_rdata; v = spi_rdvld;
    endtask

    task automatic read_check(input logic [15:0] a, input logic [31:0] e, input string n);
        logic [31:0] d;
        logic v;
        spi_read(a, d, v);
        check(n, d, e);
        check({n, "_vld"}, {31'd0, v}, 32'd1);
    endtask

    task automatic bridge_pop();
        @(negedge clk); avb2reg_read_pulse = 1'b1;
        @(negedge clk); avb2reg_read_pulse = 1'b0;
    endtask

    task automatic bridge_push(input logic [15:0] a, input logic [31:0] d);
        @(negedge clk); avb2reg_write = 1'b1; avb2reg_addr = a; avb2reg_rdata_q = d;
        @(negedge clk); avb2reg_write = 1'b0;
    endtask

    task automatic trans_up();
        @(negedge clk); avmmtransvld_up = 1'b1;
        @(negedge clk); avmmtransvld_up = 1'b0;
    endtask

    initial begin
        // Write burst of three DWords.
        add(OP_WR,   A_WB,  32'hA0A0_0000, 0, "wb_push0");
        add(OP_WR,   A_WB,  32'hA1A1_0001, 0, "wb_push1");
        add(OP_WR,   A_WB,  32'hA2A2_0002, 0, "wb_push2");
        add(OP_RD,   A_ST,  0, 32'h0000_0300, "st_wcnt3");
        add(OP_RD,   A_WB,  0, 32'hA0A0_0000, "wb_peek");
        add(OP_WR,   A_CMD, 32'h0004_0903, 0, "cmd_wr_burst");
        add(OP_OUTS, 0,     0, 32'h0004_0903, "outs_wr_burst");
        add(OP_BUSY, 0,     0, 32'd1,         "busy_wr_burst");
        add(OP_HEAD, 0,     0, 32'hA0A0_0000, "head_a0");
        add(OP_POP,  0,     0, 32'hA1A1_0001, "pop_a1");
        add(OP_POP,  0,     0, 32'hA2A2_0002, "pop_a2");
        add(OP_POP,  0,     0, 32'h0000_0000, "pop_empty_head");
        add(OP_RD,   A_ST,  0, 32'h0100_0000, "st_busy");
        add(OP_WR,   A_CMD, 32'h0000_0105, 0, "cmd_wr_while_busy");
        add(OP_OUTS, 0,     0, 32'h0004_0903, "outs_held_busy");
        add(OP_RD,   A_ST,  0, 32'h0100_0002, "st_cmd_err_busy");
        add(OP_UP,   0,     0, 0,             "up_wr");
        add(OP_OUTS, 0,     0, 32'h0004_0103, "outs_after_up");
        add(OP_BUSY, 0,     0, 32'd0,         "busy_after_up");
        add(OP_RD,   A_ST,  0, 32'h0000_0003, "st_done");
        add(OP_WR,   A_ST,  32'h0000_0003, 0, "st_clr");
        add(OP_RD,   A_ST,  0, 32'h0000_0000, "st_cleared");
        // Read burst of four DWords plus a misaddressed push.
        add(OP_WR,   A_CMD, 32'h0010_0C04, 0, "cmd_rd_burst");
        add(OP_BUSY, 0,     0, 32'd1,         "busy_rd_burst");
        add(OP_PUSH, A_RB,  32'hD000_0000, 0, "rb_push0");
        add(OP_PUSH, A_RB,  32'hD000_0001, 0, "rb_push1");
        add(OP_PUSH, A_RB,  32'hD000_0002, 0, "rb_push2");
        add(OP_PUSH, A_RB,  32'hD000_0003, 0, "rb_push3");
        add(OP_PUSH, A_WB,  32'h0000_0BAD, 0, "rb_push_badaddr");
        add(OP_RD,   A_ST,  0, 32'h0104_0040, "st_rcnt4_addr_err");
        add(OP_UP,   0,     0, 0,             "up_rd");
        add(OP_RD,   A_RB,  0, 32'hD000_0000, "rb_pop0");
        add(OP_RD,   A_RB,  0, 32'hD000_0001, "rb_pop1");
        add(OP_RD,   A_RB,  0, 32'hD000_0002, "rb_pop2");
        add(OP_RD,   A_RB,  0, 32'hD000_0003, "rb_pop3");
        add(OP_RD,   A_RB,  0, 32'h0000_0000, "rb_pop_empty");
        add(OP_RD,   A_ST,  0, 32'h0000_0061, "st_rudf");
        add(OP_WR,   A_ST,  32'h0000_007F, 0, "st_clr_all");
        // Rejected commands.
        add(OP_WR,   A_WB,  32'hB000_0000, 0, "wb_push_b0");
        add(OP_WR,   A_WB,  32'hB000_0001, 0, "wb_push_b1");
        add(OP_WR,   A_CMD, 32'h0000_0805, 0, "cmd_short_wbuf");
        add(OP_BUSY, 0,     0, 32'd0,         "busy_rejected");
        add(OP_RD,   A_ST,  0, 32'h0000_0202, "st_cmd_err_short");
        add(OP_WR,   A_ST,  32'h0000_0002, 0, "st_clr_cmd_err");
        add(OP_RD,   A_ST,  0, 32'h0000_0200, "st_cmd_err_cleared");
        add(OP_WR,   A_CMD, 32'h0000_0B01, 0, "cmd_sel3");
        add(OP_RD,   A_ST,  0, 32'h0000_0202, "st_cmd_err_sel3");
        add(OP_WR,   A_ST,  32'h0000_0002, 0, "st_clr2");
        add(OP_WR,   A_CMD, 32'h0000_0800, 0, "cmd_brst0");
        add(OP_RD,   A_ST,  0, 32'h0000_0202, "st_cmd_err_brst0");
        add(OP_WR,   A_ST,  32'h0000_0002, 0, "st_clr3");
        add(OP_OUTS, 0,     0, 32'h0010_0404, "outs_after_rejects");
        add(OP_WR,   A_CMD, 32'hE000_0207, 0, "cmd_fields_only");
        add(OP_OUTS, 0,     0, 32'h0000_0207, "outs_fields_only");
        add(OP_RD,   A_CMD, 0, 32'h0000_0207, "cmd_readback");
        add(OP_RD,   16'h0044, 0, 32'h0000_0000, "unmapped_read");

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_outs", outs(), 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_wdata", reg2avb_wdata, 32'd0);
        check("rst_rdvld", {31'd0, spi_rdvld}, 32'd0);
        rst_n = 1'b1;
        read_check(A_ST, 32'd0, "rst_status");
        read_check(A_CMD, 32'd0, "rst_cmd");

        foreach (vecs[i]) begin
            case (vecs[i].op)
                OP_WR:   spi_write(vecs[i].addr, vecs[i].data);
                OP_RD:   read_check(vecs[i].addr, vecs[i].exp, vecs[i].name);
                OP_OUTS: check(vecs[i].name, outs(), vecs[i].exp);
                OP_BUSY: check(vecs[i].name, {31'd0, busy}, vecs[i].exp);
                OP_HEAD: check(vecs[i].name, reg2avb_wdata, vecs[i].exp);
                OP_POP:  begin bridge_pop(); check(vecs[i].name, reg2avb_wdata, vecs[i].exp); end
                OP_PUSH: bridge_push(vecs[i].addr, vecs[i].data);
                OP_UP:   trans_up();
                default: ;
            endcase
        end

        // Drain B0/B1 left over from the rejected-command vectors.
        check("head_b0", reg2avb_wdata, 32'hB000_0000);
        bridge_pop();
        bridge_pop();
        check("drain_empty", reg2avb_wdata, 32'd0);

        // Overflow: 17 pushes into a 16-deep FIFO.
        for (int i = 0; i < 17; i++) spi_write(A_WB, 32'h100 + i);
        read_check(A_ST, 32'h0000_1004, "st_wovf_cnt16");
        for (int i = 0; i < 8; i++) bridge_pop();
        check("head_after_8_pops", reg2avb_wdata, 32'h108);
        @(negedge clk);
        spi_wr = 1'b1; spi_addr = A_WB; spi_wdata = 32'h1FF; avb2reg_read_pulse = 1'b1;
        @(negedge clk);
        spi_wr = 1'b0; avb2reg_read_pulse = 1'b0;
        check("head_push_pop", reg2avb_wdata, 32'h109);
        read_check(A_ST, 32'h0000_0804, "st_cnt8_push_pop");
        spi_write(A_ST, 32'h4);
        for (int i = 0; i < 7; i++) bridge_pop();
        check("head_last_pushed", reg2avb_wdata, 32'h1FF);
        bridge_pop();
        bridge_pop();
        read_check(A_ST, 32'h0000_0008, "st_wudf");
        spi_write(A_ST, 32'h8);

        // spi_rdvld timing: exactly one cycle after spi_rd.
        @(negedge clk); spi_rd = 1'b1; spi_addr = A_ST;
        check("rdvld_before", {31'd0, spi_rdvld}, 32'd0);
        @(negedge clk); spi_rd = 1'b0;
        check("rdvld_one_cycle", {31'd0, spi_rdvld}, 32'd1);
        @(negedge clk);
        check("rdvld_drops", {31'd0, spi_rdvld}, 32'd0);

        // Write and read in the same cycle: write wins, no rdvld.
        @(negedge clk); spi_wr = 1'b1; spi_rd = 1'b1; spi_addr = A_WB; spi_wdata = 32'h77;
        @(negedge clk); spi_wr = 1'b0; spi_rd = 1'b0;
        check("wr_rd_no_rdvld", {31'd0, spi_rdvld}, 32'd0);
        read_check(A_ST, 32'h0000_0100, "st_wr_rd_pushed");

        // Asynchronous reset mid-burst, between clock edges.
        spi_write(A_WB, 32'h88);
        spi_write(A_CMD, 32'h0005_0902);
        check("busy_before_rst", {31'd0, busy}, 32'd1);
        check("outs_before_rst", outs(), 32'h0005_0902);
        @(negedge clk); spi_rd = 1'b1; spi_addr = A_CMD;
        @(negedge clk); spi_rd = 1'b0;
        check("rdvld_before_rst", {31'd0, spi_rdvld}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_outs", outs(), 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_wdata", reg2avb_wdata, 32'd0);
        check("arst_rdvld", {31'd0, spi_rdvld}, 32'd0);
        check("arst_rdata", spi_rdata, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        read_check(A_ST, 32'd0, "arst_status");
        read_check(A_CMD, 32'd0, "arst_cmd");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spis_avbbuf.md
Name: spis_avbbuf

Overview:
- Register/buffer stage that sits directly upstream of the SPI-slave AVMM bridge.
- Holds the AVMM command register, a write-data FIFO and a read-data FIFO.
- The SPI register side (already synchronized into s_avmm_clk) loads the command and write data; the bridge executes the burst.
- The bridge pops write data on avb2reg_read_pulse, pushes read data on avb2reg_write, and ends the transaction with avmmtransvld_up.

Parameters:
WBUF_DEPTH, 16, write FIFO depth in DWords (power of 2, 2..256)
RBUF_DEPTH, 16, read FIFO depth in DWords (power of 2, 2..256)

Ports:
s_avmm_clk  input  1  sole clock
s_avmm_rst_n  input  1  reset; asynchronous, active-low
spi_wr  input  1  SPI-side register write strobe, one cycle
spi_rd  input  1  SPI-side register read strobe, one cycle
spi_addr  input  16  SPI-side register address
spi_wdata  input  32  SPI-side write data
spi_rdata  output  32  SPI-side read data
spi_rdvld  output  1  spi_rdata valid, one cycle
avmm_brstlen  output  8  command burst length, DWords
avmm_sel  output  2  AVMM channel select
avmm_offset  output  17  command start address
avmm_rdnwr  output  1  1=read, 0=write
avmm_transvld  output  1  command valid, level
avmmtransvld_up  input  1  transaction complete from bridge
reg2avb_wdata  output  32  write FIFO head (show-ahead)
avb2reg_read_pulse  input  1  write FIFO pop
avb2reg_write  input  1  read FIFO push
avb2reg_rdata_q  input  32  read FIFO push data
avb2reg_addr  input  16  bridge buffer select: 0x0200 = wbuf, 0x1000 = rbuf
busy  output  1  avmm_transvld is high

Behaviour:
- Reset: all outputs 0; command register 0; both FIFOs empty; status bits 0.
- Address map (SPI side):
  - 0x0000 CMD, R/W:
    - [7:0] brstlen
    - [9:8] sel
    - [10] rdnwr
    - [11] transvld
    - [28:12] offset
    - other bits read 0
  - 0x0004 STATUS:
    - [0] done
    - [1] cmd_err
    - [2] wovf
    - [3] wudf
    - [4] rovf
    - [5] rudf
    - [6] addr_err
    - bits [6:0] are sticky, write-1-to-clear
    - [15:8] wbuf count; [23:16] rbuf count; [24] busy (read-only)
  - 0x0200 WBUF: write pushes; read returns the head without popping.
  - 0x1000 RBUF: read pops; write is ignored.
  - Unmapped addresses: writes ignored, reads return 0.
- SPI reads: spi_rdata/spi_rdvld are registered and appear exactly 1 cycle after spi_rd. spi_wr and spi_rd in the same cycle: the write wins and no spi_rdvld is produced.
- CMD write with transvld=0: updates fields only, and only while not busy.
- CMD write with transvld=1: accepted only if all of the following hold:
  - not busy
  - brstlen != 0
  - sel != 3
  - write: wbuf count >= brstlen
  - read: rbuf free space >= brstlen
  - Accepted: fields and transvld latch next cycle; done clears.
  - Rejected: register unchanged; cmd_err sets.
- Any CMD write while busy: ignored; cmd_err sets.
- Command outputs are driven from the CMD register and stay constant while busy.
- avmmtransvld_up: clears transvld in the same edge and sets done. Ignored while not busy.
- Write FIFO:
  - reg2avb_wdata is the combinational head; 0 when empty.
  - Pop on avb2reg_read_pulse. Pop when empty: no change; wudf sets.
  - Push when full: data dropped; wovf sets.
  - Simultaneous push and pop: both happen, count unchanged (a push to a full FIFO still drops).
- Read FIFO:
  - Push on avb2reg_write with avb2reg_rdata_q. Push when full: dropped; rovf sets.
  - If avb2reg_addr != 0x1000 at a push: dropped; addr_err sets.
  - SPI pop when empty: returns 0; rudf sets.
  - Simultaneous push and pop: both happen.
- FIFO pointers are log2(depth)+1 bits with wrap-around. Counts are zero-extended to 8 bits.
- Reset mid-transaction: everything returns to reset values immediately (asynchronous).

Test Plan:
- 3 SPI writes to 0x0200 (A0,A1,A2), CMD write brstlen=3, rdnwr=0, sel=1, offset=0x40, transvld=1 -> next cycle avmm_transvld=1, busy=1, reg2avb_wdata=A0; pops give A1, A2, then 0; avmmtransvld_up -> transvld=0, STATUS[0]=1, wbuf count=0.
- CMD read brstlen=4 -> 4 avb2reg_write pushes (D0..D3, addr 0x1000) -> rbuf count=4; 4 SPI reads of 0x1000 return D0..D3, each spi_rdvld 1 cycle after spi_rd; 5th read returns 0 and sets rudf.
- CMD write brstlen=5 with only 2 DWords buffered -> rejected, cmd_err=1, avmm_transvld stays 0; write 0x02 to STATUS -> cmd_err=0.
- WBUF_DEPTH=16: 17 pushes -> count=16, wovf=1; push+pop in the same cycle at count=8 -> count stays 8.
- CMD write while busy -> fields unchanged, cmd_err=1; push with avb2reg_addr=0x0200 -> dropped, addr_err=1.
- Assert s_avmm_rst_n low mid-burst -> all outputs 0, counts 0, STATUS 0, without waiting for a clock edge.
